// File: rtl/mc_pkg.sv
// Shared types for the multicycle MIPS control FSM: state enum, opcodes,
// datapath select encodings and the control word carried between decode and top.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
      S_EXECUTE, S_ALUWB, S_BRANCH, S_IEXEC, S_IWB, S_JUMP
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_IMM   = 2'b10;
   localparam logic [1:0] ALUOP_FUNCT = 2'b11;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] aluop;
      logic [1:0] pc_src;
      logic       branch;
      logic       pc_write;
      logic       illegal_op;
   } ctrl_t;

   function automatic logic op_legal(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI,
         OP_ANDI, OP_ORI, OP_SLTI, OP_J: op_legal = 1'b1;
         default:                        op_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Combinational control-word decode: state (+opcode, mem_ready) -> datapath selects
// and raw strobes. Reset gating of strobes is applied by the top.
module mc_out_decode
   import mc_pkg::*;
(
   input  state_t     state,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b  = SRCB_IMMSH;
            ctrl.illegal_op = ~op_legal(opcode);
         end
         S_MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: ctrl.iord = 1'b1;
         S_MEMWB: begin
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
         end
         // held steady across wait cycles; memory commits when mem_ready is high
         S_MEMWR: begin
            ctrl.iord      = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         S_EXECUTE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.aluop     = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.aluop     = ALUOP_SUB;
            ctrl.pc_src    = PCSRC_ALUOUT;
            ctrl.branch    = 1'b1;
         end
         S_IEXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.aluop     = (opcode == OP_ADDI) ? ALUOP_ADD : ALUOP_IMM;
         end
         S_IWB: ctrl.reg_write = 1'b1;
         S_JUMP: begin
            ctrl.pc_src   = PCSRC_JUMP;
            ctrl.pc_write = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM top: state register, next-state, pc_en and strobe gating.
// Optional performance counters enabled by defining MC_PERF_CNT_EN.
module mc_controller
   import mc_pkg::*;
`ifdef MC_PERF_CNT_EN
#(
   parameter int CNT_W = 32
)
`endif
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       iord,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] aluop,
   output logic [1:0] pc_src,
   output logic       branch,
   output logic       pc_en,
   output logic       illegal_op
`ifdef MC_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
`endif
);

   state_t state, state_nxt;
   ctrl_t  ctrl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_FETCH;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:   if (mem_ready) state_nxt = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW:                     state_nxt = S_MEMADR;
               OP_RTYPE:                         state_nxt = S_EXECUTE;
               OP_BEQ:                           state_nxt = S_BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_nxt = S_IEXEC;
               OP_J:                             state_nxt = S_JUMP;
               default:                          state_nxt = S_FETCH;
            endcase
         end
         S_MEMADR:  state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   if (mem_ready) state_nxt = S_MEMWB;
         S_MEMWR:   if (mem_ready) state_nxt = S_FETCH;
         S_EXECUTE: state_nxt = S_ALUWB;
         S_IEXEC:   state_nxt = S_IWB;
         S_MEMWB, S_ALUWB, S_IWB, S_BRANCH, S_JUMP: state_nxt = S_FETCH;
         default:   state_nxt = S_FETCH;
      endcase
   end

   mc_out_decode u_dec (
      .state     (state),
      .opcode    (opcode),
      .mem_ready (mem_ready),
      .ctrl      (ctrl)
   );

   // Strobes are killed combinationally by reset so nothing commits after rst_n falls.
   assign ir_write   = ctrl.ir_write   & rst_n;
   assign mem_write  = ctrl.mem_write  & rst_n;
   assign reg_write  = ctrl.reg_write  & rst_n;
   assign illegal_op = ctrl.illegal_op & rst_n;
   assign pc_en      = rst_n & (ctrl.pc_write | (ctrl.branch & zero));

   assign iord       = ctrl.iord;
   assign reg_dst    = ctrl.reg_dst;
   assign mem_to_reg = ctrl.mem_to_reg;
   assign alu_src_a  = ctrl.alu_src_a;
   assign alu_src_b  = ctrl.alu_src_b;
   assign aluop      = ctrl.aluop;
   assign pc_src     = ctrl.pc_src;
   assign branch     = ctrl.branch;

`ifdef MC_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (state != S_FETCH && state_nxt == S_FETCH) instr_cnt <= instr_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Randomized self-checking bench for mc_controller against an instruction-level
// model: per-opcode step sequences with expected control words from the op table.
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       zero, mem_ready;
   logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
   logic [1:0] alu_src_b, aluop, pc_src;
   logic       branch, pc_en, illegal_op;
`ifdef MC_PERF_CNT_EN
   logic [31:0] cycle_cnt, instr_cnt;
`endif

   int checks = 0, failures = 0;
   int step = 0, m_cycles = 0, m_instrs = 0;
   logic [5:0] cur_op = 6'b0;

   always #5 clk = ~clk;

   mc_controller dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .aluop(aluop), .pc_src(pc_src), .branch(branch),
      .pc_en(pc_en), .illegal_op(illegal_op)
`ifdef MC_PERF_CNT_EN
      , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // instruction length in cycles with zero-wait memory
   function automatic int seq_len(input logic [5:0] op);
      case (op)
         6'b100011: return 5;
         6'b101011, 6'b000000, 6'b001000, 6'b001100, 6'b001101, 6'b001010: return 4;
         6'b000100, 6'b000010: return 3;
         default: return 2;
      endcase
   endfunction

   function automatic bit is_mem(input logic [5:0] op);
      return op == 6'b100011 || op == 6'b101011;
   endfunction

   // {iord,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,srca,srcb,aluop,pcsrc,branch,pc_en,illegal}
   function automatic logic [16:0] exp_word(input logic [5:0] op, input int s, input bit mr, input bit z);
      bit io = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0, br = 0, pe = 0, ill = 0;
      bit [1:0] sb = 0, ao = 0, ps = 0;
      int n = seq_len(op);
      if (s == 0) begin sb = 2'b01; irw = mr; pe = mr; end
      else if (s == 1) begin sb = 2'b11; ill = (n == 2); end
      else if (is_mem(op)) begin
         if (s == 2) begin sa = 1; sb = 2'b10; end
         else if (op == 6'b100011 && s == 3) io = 1;
         else if (op == 6'b100011) begin m2r = 1; rw = 1; end
         else begin io = 1; mw = 1; end
      end else if (op == 6'b000000) begin
         if (s == 2) begin sa = 1; ao = 2'b11; end
         else begin rd = 1; rw = 1; end
      end else if (op == 6'b000100) begin
         sa = 1; ao = 2'b01; ps = 2'b01; br = 1; pe = z;
      end else if (op == 6'b000010) begin
         ps = 2'b10; pe = 1;
      end else begin
         if (s == 2) begin sa = 1; sb = 2'b10; ao = (op == 6'b001000) ? 2'b00 : 2'b10; end
         else rw = 1;
      end
      return {io, mw, irw, rd, m2r, rw, sa, sb, ao, ps, br, pe, ill};
   endfunction

   function automatic logic [16:0] got_word();
      return {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
              alu_src_b, aluop, pc_src, branch, pc_en, illegal_op};
   endfunction

   // one clock: drive inputs just after an edge, check mid-cycle, advance the model
   task automatic cyc(input bit mr, input bit z);
      bit stall;
      mem_ready = mr;
      zero = z;
      #2;
      chk("ctl", 32'(got_word()), 32'(exp_word(cur_op, step, mr, z)));
`ifdef MC_PERF_CNT_EN
      chk("cycle_cnt", cycle_cnt, 32'(m_cycles));
      chk("instr_cnt", instr_cnt, 32'(m_instrs));
`endif
      @(posedge clk);
      #1;
      m_cycles++;
      stall = !mr && (step == 0 || (step == 3 && is_mem(cur_op)));
      if (!stall) begin
         if (step == seq_len(cur_op) - 1) begin step = 0; m_instrs++; end
         else step++;
      end
   endtask

   // mrmode: 0 always ready, 1 random, 2 three waits in the store cycle; zmode 2 = random
   task automatic do_instr(input logic [5:0] op, input int mrmode, input int zmode);
      int waits = 0, n = 0, mwcnt = 0;
      bit mr, z;
      cur_op = op;
      opcode = op;
      do begin
         mr = (mrmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (mrmode == 2 && step == 3 && waits < 3) begin mr = 0; waits++; end
         z = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
         if (step == 3 && mem_write) mwcnt++;
         cyc(mr, z);
         n++;
      end while (step != 0 && n < 100);
      if (n >= 100) chk("timeout", 1, 0);
      if (mrmode == 2) chk("sw_mw_cycles", mwcnt, 4);
   endtask

   task automatic reset_model();
      step = 0; m_cycles = 0; m_instrs = 0;
   endtask

   logic [5:0] ops [9];

   initial begin
      ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
              6'b001100, 6'b001101, 6'b001010, 6'b000010};
      rst_n = 0; mem_ready = 1; zero = 1; opcode = 6'b0;
      #3;
      chk("rst_word", 32'(got_word()), 32'(exp_word(6'b0, 0, 0, 0)));
      @(posedge clk); @(posedge clk); #1;
      chk("rst_word_held", 32'(got_word()), 32'(exp_word(6'b0, 0, 0, 0)));
`ifdef MC_PERF_CNT_EN
      chk("rst_cycle_cnt", cycle_cnt, 0);
      chk("rst_instr_cnt", instr_cnt, 0);
`endif
      rst_n = 1;
      reset_model();

      // lw, zero-wait: five cycles, writeback from memory on the last
      opcode = 6'b100011; #1;
      chk("first_ir_write", ir_write, 1);
      chk("first_pc_en", pc_en, 1);
      #1;
      do_instr(6'b100011, 0, 0);
      chk("lw_cycles", m_cycles, 5);
`ifdef MC_PERF_CNT_EN
      chk("lw_instr_cnt", instr_cnt, 1);
`endif
      do_instr(6'b101011, 2, 0);     // sw with 3 wait cycles
      do_instr(6'b000100, 0, 1);     // beq taken
      do_instr(6'b000100, 0, 0);     // beq not taken
      do_instr(6'b111111, 0, 0);     // illegal
      do_instr(6'b000010, 0, 0);
      do_instr(6'b001000, 0, 0);
      do_instr(6'b001101, 0, 0);

      for (int i = 0; i < 300; i++) begin
         logic [5:0] op;
         op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)];
         do_instr(op, int'($urandom_range(0, 1)), 2);
      end

      // reset dropped during ALUWB of an R-type
      cur_op = 6'b000000; opcode = 6'b000000;
      while (step != 3) cyc(1, 0);
      rst_n = 0;
      #1;
      chk("midrst_reg_write", reg_write, 0);
      chk("midrst_word", 32'(got_word()), 32'(exp_word(6'b0, 0, 0, 0)));
`ifdef MC_PERF_CNT_EN
      chk("midrst_cycle_cnt", cycle_cnt, 0);
      chk("midrst_instr_cnt", instr_cnt, 0);
`endif
      @(posedge clk); #1;
      rst_n = 1;
      reset_model();
      do_instr(6'b000000, 0, 0);
      do_instr(6'b001010, 1, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control FSM for the MIPS datapath. It sequences one shared ALU, one unified instruction/data memory and the register file across several cycles per instruction. It decodes the opcode held in the instruction register and drives the datapath mux selects and write strobes each cycle. Memory accesses use a ready handshake so the core can sit in front of wait-stated memory.

## Interface
- `CNT_W`, 32, width of performance counters (used only with `MC_PERF_CNT_EN`)
- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `opcode`  in  6  instr[31:26] from instruction register, stable after FETCH
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes current access this cycle
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_write`  out  1  memory write strobe
- `ir_write`  out  1  instruction register load
- `reg_dst`  out  1  write register: 0 = rt, 1 = rd
- `mem_to_reg`  out  1  writeback data: 0 = ALUOut, 1 = memory data
- `reg_write`  out  1  register file write strobe
- `alu_src_a`  out  1  0 = PC, 1 = register A
- `alu_src_b`  out  2  00 = B, 01 = const 4, 10 = signed imm, 11 = imm<<2
- `aluop`  out  2  00 = add, 01 = sub, 10 = immediate op, 11 = R-type funct
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `branch`  out  1  branch-in-progress
- `pc_en`  out  1  PC load = pc_write | (branch & zero)
- `illegal_op`  out  1  one-cycle pulse on unsupported opcode
- `cycle_cnt`, `instr_cnt`  out  CNT_W each  performance counters (only with `MC_PERF_CNT_EN`)

## Operation
- Moore FSM. Outputs are decoded from the state register (plus `mem_ready`/`zero` where noted). Any output not listed for a state is 0.
- **FETCH**: alu_src_b=01, aluop=00, pc_src=00, `ir_write`=`pc_write`=`mem_ready`.
  - Next: DECODE if `mem_ready`, else stay in FETCH.
- **DECODE**: alu_src_b=11, aluop=00 (branch target precompute).
  - Next by opcode: 100011/101011 → MEMADR; 000000 → EXECUTE; 000100 → BRANCH; 001000/001100/001101/001010 → IEXEC; 000010 → JUMP.
  - Any other opcode → FETCH with `illegal_op`=1 this cycle; no strobes.
- **MEMADR**: alu_src_a=1, alu_src_b=10, aluop=00. Next: MEMRD for lw, MEMWR for sw.
- **MEMRD**: iord=1. Next: MEMWB on `mem_ready`, else stay.
- **MEMWB**: mem_to_reg=1, reg_write=1 → FETCH.
- **MEMWR**: iord=1, mem_write=1, held until `mem_ready`, then → FETCH.
- **EXECUTE**: alu_src_a=1, alu_src_b=00, aluop=11 → ALUWB.
- **ALUWB**: reg_dst=1, reg_write=1 → FETCH.
- **BRANCH**: alu_src_a=1, alu_src_b=00, aluop=01, pc_src=01, branch=1 → FETCH.
- **IEXEC**: alu_src_a=1, alu_src_b=10; aluop=00 for addi, 10 for andi/ori/slti → IWB.
- **IWB**: reg_write=1 (reg_dst=0, mem_to_reg=0) → FETCH.
- **JUMP**: pc_src=10, pc_write=1 → FETCH.

## Timing
- Reset: state = FETCH asynchronously. While `rst_n`=0 every strobe (`ir_write`, `pc_en`, `mem_write`, `reg_write`, `illegal_op`) is forced 0 combinationally. Selects show FETCH values: alu_src_b=01, all others 0. Counters reset to 0.
- Reset mid-instruction aborts immediately. No partial writeback completes after `rst_n` falls.
- Cycles per instruction with zero-wait memory: lw 5, sw 4, R-type 4, I-type 4, beq 3, j 3, illegal 2. Each wait cycle (`mem_ready`=0 in FETCH/MEMRD/MEMWR) adds 1.
- `mem_write` and `iord` stay constant across MEMWR wait cycles. Memory must sample the write only on the cycle with `mem_ready`=1.
- `pc_en` in BRANCH is combinational on `zero` in the same cycle.

## Configuration
- `MC_PERF_CNT_EN` defined:
  - `cycle_cnt` increments every cycle out of reset.
  - `instr_cnt` increments on every transition into FETCH from a non-FETCH state, including the illegal-opcode path.
  - Both counters wrap modulo 2^CNT_W.
- `MC_PERF_CNT_EN` undefined: counter ports and logic are absent; FSM behaviour is identical.

## Structure
- Shared package `mc_pkg` holds:
  - state enum;
  - opcode constants (RTYPE, LW, SW, BEQ, ADDI, ANDI, ORI, SLTI, J);
  - aluop, alu_src_b and pc_src encodings.
- Sub-module `mc_out_decode`: purely combinational state (+opcode) → control word. The top holds the state register, next-state logic, `pc_en` and counters.

## Test plan
- Reset with `mem_ready`=1 → state FETCH, all strobes 0 while `rst_n`=0. First cycle after release: `ir_write`=`pc_en`=1, alu_src_b=01.
- lw (opcode 100011), `mem_ready` held 1 → FETCH, DECODE, MEMADR, MEMRD, MEMWB. `reg_write`=1 with mem_to_reg=1 on cycle 5; `instr_cnt`=1.
- sw with `mem_ready` low for 3 cycles in MEMWR → `mem_write`=1, iord=1 for 4 cycles. Back to FETCH on the 4th.
- beq with zero=1 then zero=0 → `pc_en`=1, pc_src=01 in BRANCH for the first; `pc_en`=0 for the second. 3 cycles each.
- Opcode 111111 → `illegal_op`=1 for one cycle in DECODE, no writes. Next cycle is FETCH.
- `rst_n` dropped during ALUWB of an R-type → `reg_write` falls immediately, state returns to FETCH, counters read 0.
